// File: rtl/blockram_pkg.sv
// Shared definitions for logic sitting on the boot/BIOS block-RAM array side.
package blockram_pkg;

    localparam int unsigned BR_WORD_AW = 17;
    localparam int unsigned BR_DATA_W  = 32;
    localparam int unsigned BR_BYTE_AW = 19;

    typedef enum logic [1:0] {IDLE, READ, RESP} rd_state_t;

    // Words 0x13000-0x18FFF are not populated in the array.
    function automatic logic br_is_hole(input logic [BR_WORD_AW-1:0] word_addr);
        return word_addr[16] && (word_addr[15:12] >= 4'd3) && (word_addr[15:12] <= 4'd8);
    endfunction

endpackage

// File: rtl/blockram_rd_ctrl.sv
// Read controller in front of the boot block-RAM: single and wrapping burst reads.
// Optional one-entry hit buffer enabled by defining BLOCKRAM_RD_HITBUF_EN.
module blockram_rd_ctrl
    import blockram_pkg::*;
#(
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [BR_BYTE_AW-1:0] req_addr,
    input  logic                  req_burst,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [BR_DATA_W-1:0]  rsp_data,
    output logic                  rsp_last,
    output logic                  rsp_err,
    output logic [BR_WORD_AW-1:0] mem_addr,
    input  logic [BR_DATA_W-1:0]  mem_data
);

    localparam int unsigned BeatW = $clog2(BURST_LEN);
    localparam logic [2:0] LatMax = 3'(RD_LAT);
    localparam logic [BR_WORD_AW-1:0] WrapMask = BR_WORD_AW'(BURST_LEN - 1);

    // Critical-word-first: only the in-block index bits advance.
    function automatic logic [BR_WORD_AW-1:0] wrap_inc(input logic [BR_WORD_AW-1:0] a);
        return (a & ~WrapMask) | ((a + BR_WORD_AW'(1)) & WrapMask);
    endfunction

    rd_state_t             state_q;
    logic [BR_WORD_AW-1:0] mem_addr_q;
    logic                  burst_q;
    logic                  misalign_q;
    logic [BeatW-1:0]      beat_q;
    logic [2:0]            lat_q;
    logic                  rsp_valid_q;
    logic                  rsp_last_q;
    logic                  rsp_err_q;
    logic [BR_DATA_W-1:0]  rsp_data_q;

    logic                  capture;
    logic                  cap_hole;
    logic                  hit;
    logic [BR_DATA_W-1:0]  hit_data;
    logic [BR_WORD_AW-1:0] req_word;

    assign req_word = req_addr[BR_BYTE_AW-1:2];
    assign capture  = (state_q == READ) && (lat_q == LatMax);
    assign cap_hole = br_is_hole(mem_addr_q);

`ifdef BLOCKRAM_RD_HITBUF_EN
    logic                  hb_valid_q;
    logic [BR_WORD_AW-1:0] hb_addr_q;
    logic [BR_DATA_W-1:0]  hb_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hb_valid_q <= 1'b0;
            hb_addr_q  <= '0;
            hb_data_q  <= '0;
        end else if (capture && !cap_hole) begin
            hb_valid_q <= 1'b1;
            hb_addr_q  <= mem_addr_q;
            hb_data_q  <= mem_data;
        end
    end

    assign hit = !req_burst && (req_addr[1:0] == 2'b00) && !br_is_hole(req_word) &&
                 hb_valid_q && (hb_addr_q == req_word);
    assign hit_data = hb_data_q;
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            burst_q     <= 1'b0;
            misalign_q  <= 1'b0;
            beat_q      <= '0;
            lat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        burst_q    <= req_burst;
                        misalign_q <= |req_addr[1:0];
                        beat_q     <= '0;
                        lat_q      <= '0;
                        if (hit) begin
                            // Buffered word: respond next cycle, array untouched.
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= hit_data;
                            rsp_last_q  <= 1'b1;
                            rsp_err_q   <= 1'b0;
                        end else begin
                            state_q    <= READ;
                            mem_addr_q <= req_word;
                        end
                    end
                end
                READ: begin
                    if (capture) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= cap_hole ? '0 : mem_data;
                        rsp_err_q   <= misalign_q || cap_hole;
                        rsp_last_q  <= !burst_q || (&beat_q);
                    end else begin
                        lat_q <= lat_q + 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (burst_q && !(&beat_q)) begin
                            state_q    <= READ;
                            beat_q     <= beat_q + 1'b1;
                            lat_q      <= '0;
                            mem_addr_q <= wrap_inc(mem_addr_q);
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE) && !rst;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;
    assign rsp_err   = rsp_err_q;
    assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_blockram_rd_ctrl.sv
// Self-checking bench for blockram_rd_ctrl with a pipelined array model and a
// transaction-level reference model (hit-buffer expectations follow BLOCKRAM_RD_HITBUF_EN).
module tb_blockram_rd_ctrl;

    localparam int unsigned RD_LAT    = 1;
    localparam int unsigned BURST_LEN = 4;
    localparam int          BL        = BURST_LEN;
    localparam int          MissLat   = RD_LAT + 2;
`ifdef BLOCKRAM_RD_HITBUF_EN
    localparam bit HitBufEn = 1'b1;
`else
    localparam bit HitBufEn = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [18:0] req_addr;
    logic        req_burst;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        rsp_err;
    logic [16:0] mem_addr;
    logic [31:0] mem_data;

    int n_cmp = 0;
    int n_err = 0;

    // Reference-model state
    int mem_model;
    bit hb_v;
    int hb_a;

    blockram_rd_ctrl #(
        .RD_LAT   (RD_LAT),
        .BURST_LEN(BURST_LEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_burst(req_burst),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_last (rsp_last),
        .rsp_err  (rsp_err),
        .mem_addr (mem_addr),
        .mem_data (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] arr_word(input int w);
        if (w == 4) return 32'hDEAD_BEEF;
        return (32'(w) * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic bit tb_hole(input int w);
        return (w >= 'h13000) && (w <= 'h18FFF);
    endfunction

    // Array: samples mem_addr on each edge, data valid RD_LAT edges later.
    logic [31:0] pipe [4];
    always @(posedge clk) begin
        pipe[0] <= arr_word(int'(mem_addr));
        for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_data = pipe[RD_LAT-1];

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        mem_model = 0;
        hb_v      = 1'b0;
    endtask

    task automatic run_txn(input logic [18:0] addr, input bit burst, input int hold_beat,
                           input int hold_cyc);
        int          w0, w, nb, lat;
        bit          hit, mis, hole;
        logic [31:0] exp_d;
        logic        exp_e, exp_l;
        logic [16:0] exp_ma;
        w0  = int'(addr[18:2]);
        mis = (addr[1:0] != 2'b00);
        nb  = burst ? BL : 1;
        hit = HitBufEn && !burst && !mis && !tb_hole(w0) && hb_v && (hb_a == w0);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = addr;
        req_burst = burst;
        rsp_ready = (hold_beat != 0);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL req_ready_idle: got %b want 1", req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int b = 0; b < nb; b++) begin
            if (b > 0) begin
                @(negedge clk);
                rsp_ready = (b != hold_beat);
            end
            w      = (w0 / BL) * BL + (w0 + b) % BL;
            hole   = tb_hole(w);
            exp_d  = hole ? 32'h0 : arr_word(w);
            exp_e  = mis || hole;
            exp_l  = (b == nb - 1);
            exp_ma = hit ? 17'(mem_model) : 17'(w);
            lat    = 1;
            while (rsp_valid !== 1'b1 && lat < 64) begin
                n_cmp++;
                if (req_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL req_ready_busy: got %b want 0", req_ready);
                end
                @(negedge clk);
                lat++;
            end
            n_cmp++;
            if (rsp_valid !== 1'b1) begin
                n_err++;
                $display("FAIL rsp_timeout: addr %h beat %0d got no rsp_valid", addr, b);
                do_reset();
                return;
            end
            n_cmp++;
            if (b == 0 && lat != (hit ? 1 : MissLat)) begin
                n_err++;
                $display("FAIL first_latency: addr %h got %0d want %0d", addr, lat,
                         hit ? 1 : MissLat);
            end else if (b > 0 && lat < MissLat) begin
                n_err++;
                $display("FAIL beat_gap: addr %h beat %0d got %0d want >= %0d", addr, b, lat,
                         MissLat);
            end
            n_cmp++;
            if (rsp_data !== exp_d) begin
                n_err++;
                $display("FAIL rsp_data: addr %h beat %0d got %h want %h", addr, b, rsp_data,
                         exp_d);
            end
            n_cmp++;
            if (rsp_last !== exp_l) begin
                n_err++;
                $display("FAIL rsp_last: addr %h beat %0d got %b want %b", addr, b, rsp_last,
                         exp_l);
            end
            n_cmp++;
            if (rsp_err !== exp_e) begin
                n_err++;
                $display("FAIL rsp_err: addr %h beat %0d got %b want %b", addr, b, rsp_err,
                         exp_e);
            end
            n_cmp++;
            if (mem_addr !== exp_ma) begin
                n_err++;
                $display("FAIL mem_addr: addr %h beat %0d got %h want %h", addr, b, mem_addr,
                         exp_ma);
            end
            n_cmp++;
            if (req_ready !== 1'b0) begin
                n_err++;
                $display("FAIL req_ready_resp: got %b want 0", req_ready);
            end
            if (b == hold_beat) begin
                repeat (hold_cyc) begin
                    @(negedge clk);
                    n_cmp++;
                    if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_last !== exp_l ||
                        rsp_err !== exp_e || req_ready !== 1'b0) begin
                        n_err++;
                        $display("FAIL held_beat: beat %0d got v%b d%h l%b e%b r%b want v1 d%h l%b e%b r0",
                                 b, rsp_valid, rsp_data, rsp_last, rsp_err, req_ready, exp_d,
                                 exp_l, exp_e);
                    end
                end
                rsp_ready = 1'b1;
            end
            if (!hit && !hole) begin
                hb_v = 1'b1;
                hb_a = w;
            end
            if (!hit) mem_model = w;
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL txn_end: got valid %b ready %b want valid 0 ready 1", rsp_valid,
                     req_ready);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_err++; $display("FAIL rst_req_ready: got %b want 0", req_ready);
        end
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_last !== 1'b0 || rsp_err !== 1'b0) begin
            n_err++;
            $display("FAIL rst_rsp_flags: got v%b l%b e%b want 000", rsp_valid, rsp_last,
                     rsp_err);
        end
        n_cmp++;
        if (rsp_data !== 32'h0) begin
            n_err++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data);
        end
        n_cmp++;
        if (mem_addr !== 17'h0) begin
            n_err++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_rst: got ready %b valid %b want 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_single();
        run_txn(19'h00010, 1'b0, -1, 0);
    endtask

    task automatic test_burst();
        run_txn(19'h00018, 1'b1, -1, 0);
        run_txn(19'h00000, 1'b1, -1, 0);
    endtask

    task automatic test_hole();
        run_txn({17'h14000, 2'b00}, 1'b0, -1, 0);
        run_txn({17'h12000, 2'b00}, 1'b0, -1, 0);
        run_txn({17'h12FFF, 2'b00}, 1'b0, -1, 0);
        run_txn({17'h13000, 2'b00}, 1'b0, -1, 0);
        run_txn({17'h18FFC, 2'b00}, 1'b1, -1, 0);
        run_txn({17'h19000, 2'b00}, 1'b0, -1, 0);
    endtask

    task automatic test_misalign();
        run_txn(19'h00011, 1'b0, -1, 0);
        run_txn(19'h0001B, 1'b1, -1, 0);
    endtask

    task automatic test_backpressure();
        run_txn(19'h00020, 1'b1, 1, 10);
        run_txn(19'h00104, 1'b0, 0, 7);
    endtask

    task automatic test_reset_mid();
        int k;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 19'h00040;
        req_burst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (rsp_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_err++; $display("FAIL midrst_setup: got valid %b want 1", rsp_valid);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || mem_addr !== 17'h0) begin
            n_err++;
            $display("FAIL midrst_async: got valid %b ready %b mem_addr %h want 0 0 0",
                     rsp_valid, req_ready, mem_addr);
        end
        @(negedge clk);
        rst       = 1'b0;
        rsp_ready = 1'b1;
        mem_model = 0;
        hb_v      = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++; $display("FAIL midrst_ready: got %b want 1", req_ready);
        end
        k = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) k++;
        end
        n_cmp++;
        if (k != 0) begin
            n_err++; $display("FAIL midrst_ghost_beat: got %0d valid cycles want 0", k);
        end
        run_txn(19'h00010, 1'b0, -1, 0);
    endtask

    task automatic test_hitbuf();
        run_txn(19'h00010, 1'b0, -1, 0);
        run_txn(19'h00010, 1'b0, -1, 0);
        run_txn(19'h00011, 1'b0, -1, 0);
        run_txn(19'h00014, 1'b1, -1, 0);
        run_txn(19'h00014, 1'b0, 0, 3);
    endtask

    task automatic test_random();
        logic [18:0] a;
        logic [16:0] w;
        bit          br;
        int          hb;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: a = 19'($urandom);
                1: begin
                    w = 17'('h13000 + $urandom_range(0, 'h5FFF));
                    a = {w, 2'($urandom)};
                end
                2: a = {17'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b00};
                default: begin
                    case ($urandom_range(0, 4))
                        0: w = 17'h12FFF;
                        1: w = 17'h13000;
                        2: w = 17'h18FFF;
                        3: w = 17'h19000;
                        default: w = 17'h1FFFF;
                    endcase
                    a = {w, 2'b00};
                end
            endcase
            br = ($urandom_range(0, 2) == 0);
            hb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, br ? BL - 1 : 0) : -1;
            run_txn(a, br, hb, $urandom_range(1, 5));
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_burst = 1'b0;
        rsp_ready = 1'b1;
        mem_model = 0;
        hb_v      = 1'b0;
        hb_a      = 0;
        test_reset();
        test_single();
        test_burst();
        test_hole();
        test_misalign();
        test_backpressure();
        test_reset_mid();
        test_hitbuf();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
